// File: rtl/tx_rx_pkg.sv
// Shared definitions for both ends of the synchronous TX->RX link: word geometry
// and the state encodings of the transmit and receive state machines.
package tx_rx_pkg;

    localparam int TX_DATA_W    = 8;
    localparam int TX_NUM_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        SEND,
        GAP,
        DONE
    } tx_state_e;

    // Receiver side lives here too so both ends agree on one definition.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_SHR,
        RX_WRITE,
        RX_INC,
        RX_FINISH
    } rx_state_e;

endpackage

// File: rtl/tx_sm_if.sv
// Host-load, burst-control and serial-link signals of the transmit controller.
interface tx_sm_if
    import tx_rx_pkg::*;
#(
    parameter int DATA_W    = TX_DATA_W,
    parameter int NUM_WORDS = TX_NUM_WORDS
);
    localparam int AW = $clog2(NUM_WORDS);

    logic              ld_en;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              start;
    logic              rx_ready;
    logic              tx_valid;
    logic              tx_data;
    logic [AW-1:0]     word_idx;
    logic              busy;
    logic              tx_done;
    tx_state_e         state;

    // Link handshake: a word starts only in a cycle where rx_ready is sampled high
    // while waiting; tx_valid then stays high for DATA_W consecutive cycles, each
    // qualifying one tx_data bit (LSB first), and rx_ready is ignored meanwhile.
    modport master (
        output ld_en, ld_addr, ld_data, start, rx_ready,
        input  tx_valid, tx_data, word_idx, busy, tx_done, state
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, start, rx_ready,
        output tx_valid, tx_data, word_idx, busy, tx_done, state
    );

endinterface

// File: rtl/tx_shift_reg.sv
// Parallel-load, right-shifting serialiser; the LSB is the bit on the line.
module tx_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] din_i,
    output logic              dout_o
);

    logic [DATA_W-1:0] shreg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= din_i;
        end else if (shift_i) begin
            shreg_q <= {1'b0, shreg_q[DATA_W-1:1]};
        end
    end

    assign dout_o = shreg_q[0];

endmodule

// File: rtl/tx_sm.sv
// Transmit controller: buffers NUM_WORDS host-loaded words and serialises them one
// word at a time to the receiver, pulsing tx_done after the last word.
module tx_sm
    import tx_rx_pkg::*;
#(
    parameter int DATA_W    = TX_DATA_W,
    parameter int NUM_WORDS = TX_NUM_WORDS
) (
    input logic   clk,
    input logic   rst_n,
    tx_sm_if.slave bus
);

    localparam int AW = $clog2(NUM_WORDS);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_W - 1);
    localparam logic [AW-1:0] LAST_WORD = AW'(NUM_WORDS - 1);

    tx_state_e         state_q;
    logic [AW-1:0]     word_idx_q;
    logic [CW-1:0]     bit_cnt_q;
    logic              tx_valid_q;
    logic              busy_q;
    logic              tx_done_q;
    logic [DATA_W-1:0] buf_q [NUM_WORDS];

    logic sh_load;
    logic sh_shift;
    logic sh_bit;

    assign sh_load  = (state_q == WAIT_RDY) && bus.rx_ready;
    assign sh_shift = (state_q == SEND);

    // Buffer only accepts writes while idle, so a burst always sends a frozen snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else if (bus.ld_en && (state_q == IDLE)) begin
            buf_q[bus.ld_addr] <= bus.ld_data;
        end
    end

    tx_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .din_i   (buf_q[word_idx_q]),
        .dout_o  (sh_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            bit_cnt_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= WAIT_RDY;
                        word_idx_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (bus.rx_ready) begin
                        state_q    <= SEND;
                        bit_cnt_q  <= '0;
                        tx_valid_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        tx_valid_q <= 1'b0;
                        if (word_idx_q == LAST_WORD) begin
                            state_q   <= DONE;
                            tx_done_q <= 1'b1;
                        end else begin
                            state_q    <= GAP;
                            word_idx_q <= word_idx_q + AW'(1);
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                    end
                end
                GAP: begin
                    state_q <= WAIT_RDY;
                end
                DONE: begin
                    state_q    <= IDLE;
                    word_idx_q <= '0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    word_idx_q <= '0;
                    tx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // The serial bit is forced low outside SEND so the line is quiet between words.
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_valid_q & sh_bit;
    assign bus.word_idx = word_idx_q;
    assign bus.busy     = busy_q;
    assign bus.tx_done  = tx_done_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_tx_sm.sv
// Randomised scoreboard bench for tx_sm: a word-level model predicts each burst,
// and a monitor reassembles serial words and checks them against the predictions.
module tb_tx_sm;
    import tx_rx_pkg::*;

    localparam int DATA_W    = 8;
    localparam int NUM_WORDS = 4;
    localparam int AW        = 2;

    logic clk;
    logic rst_n;

    tx_sm_if #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS)) bus ();

    tx_sm #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout actual=expired required=finish");
        $fatal(1, "simulation time limit");
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [AW+DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] model_buf [NUM_WORDS];
    bit model_busy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst is simply the whole buffer in index order.
    task automatic model_write(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        if (!model_busy) model_buf[a] = d;
    endtask

    task automatic model_start();
        if (!model_busy) begin
            for (int i = 0; i < NUM_WORDS; i++) exp_q.push_back({AW'(i), model_buf[i]});
            model_busy = 1;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < NUM_WORDS; i++) model_buf[i] = '0;
        model_busy = 0;
    endtask

    // ---------------- monitor ----------------
    int               mon_nb = 0;
    logic [DATA_W-1:0] mon_word;
    logic [AW-1:0]     mon_idx;
    bit               done_pend = 0;

    initial begin
        logic [AW+DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_nb    = 0;
                done_pend = 0;
            end else begin
                check("tx_done", {31'd0, bus.tx_done}, {31'd0, done_pend});
                done_pend = 0;
                if (bus.tx_valid) begin
                    if (mon_nb == 0) mon_idx = bus.word_idx;
                    else check("idx_stable", {30'd0, bus.word_idx}, {30'd0, mon_idx});
                    mon_word[mon_nb] = bus.tx_data;
                    mon_nb++;
                    if (mon_nb == DATA_W) begin
                        mon_nb = 0;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_word actual=%0h required=none", mon_word);
                        end else begin
                            e = exp_q.pop_front();
                            check("word_data", {24'd0, mon_word}, {24'd0, e[DATA_W-1:0]});
                            check("word_idx", {30'd0, mon_idx}, {30'd0, e[AW+DATA_W-1:DATA_W]});
                            if (e[AW+DATA_W-1:DATA_W] == AW'(NUM_WORDS - 1)) done_pend = 1;
                        end
                    end
                end else begin
                    if (mon_nb != 0) begin
                        check("word_broken", mon_nb, 0);
                        mon_nb = 0;
                    end
                    check("idle_data", {31'd0, bus.tx_data}, 32'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_word(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        model_write(a, d);
        @(negedge clk);
        bus.ld_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        model_start();
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input bit rnd);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        while (!seen && n < max_cyc) begin
            bus.start = 1'b0;
            bus.ld_en = 1'b0;
            if (rnd) begin
                bus.rx_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) begin
                    bus.start = 1'b1;
                    model_start();
                end
                if ($urandom_range(0, 7) == 0) begin
                    bus.ld_en   = 1'b1;
                    bus.ld_addr = AW'($urandom_range(0, NUM_WORDS - 1));
                    bus.ld_data = DATA_W'($urandom_range(0, 255));
                    model_write(bus.ld_addr, bus.ld_data);
                end
            end
            @(negedge clk);
            n++;
            if (bus.tx_done) seen = 1;
        end
        bus.start = 1'b0;
        bus.ld_en = 1'b0;
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        model_busy = 0;
        check("idle_after_done", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic wait_word1(output bit ok);
        int n;
        n = 0;
        while (!(bus.tx_valid && bus.word_idx == AW'(1)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 200);
        if (!ok) check("word1_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        rst_n        = 1'b0;
        bus.ld_en    = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        bus.start    = 1'b0;
        bus.rx_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_data", {31'd0, bus.tx_data}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.tx_done}, 32'd0);
        check("rst_idx", {30'd0, bus.word_idx}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed burst with the receiver always ready, plus start latency.
        load_word(2'd0, 8'hA5);
        load_word(2'd1, 8'h3C);
        load_word(2'd2, 8'hFF);
        load_word(2'd3, 8'h01);
        bus.rx_ready = 1'b1;
        bus.start    = 1'b1;
        model_start();
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("lat_c1_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("lat_c1_busy", {31'd0, bus.busy}, 32'd1);
        @(posedge clk);
        #1;
        check("lat_c2_valid", {31'd0, bus.tx_valid}, 32'd1);
        check("lat_c2_bit0", {31'd0, bus.tx_data}, 32'd1);
        @(negedge clk);
        wait_done(200, 0);

        // Write and start in the same idle cycle: the new data goes out.
        bus.ld_en   = 1'b1;
        bus.ld_addr = 2'd0;
        bus.ld_data = 8'h81;
        bus.start   = 1'b1;
        model_write(2'd0, 8'h81);
        model_start();
        @(negedge clk);
        bus.ld_en = 1'b0;
        bus.start = 1'b0;
        wait_done(200, 0);

        // Receiver not ready: parks in WAIT_RDY, then sends the cycle after ready.
        bus.rx_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            check("park_valid", {31'd0, bus.tx_valid}, 32'd0);
            check("park_busy", {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
        end
        bus.rx_ready = 1'b1;
        @(negedge clk);
        check("rdy_first_bit", {31'd0, bus.tx_valid}, 32'd1);
        wait_done(200, 0);

        // Load and restart during word 1 are both ignored.
        pulse_start();
        wait_word1(ok);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 2'd2;
        bus.ld_data = 8'h00;
        bus.start   = 1'b1;
        model_write(2'd2, 8'h00);
        model_start();
        @(negedge clk);
        bus.ld_en = 1'b0;
        bus.start = 1'b0;
        wait_done(200, 0);
        repeat (4) @(negedge clk);
        check("no_second_burst", {31'd0, bus.busy}, 32'd0);

        // Reset at bit 4 of word 1 aborts and clears the buffer.
        pulse_start();
        wait_word1(ok);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_idx", {30'd0, bus.word_idx}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_done(200, 0);

        // Randomised bursts with a flaky receiver, stray starts and loads.
        for (int b = 0; b < 10; b++) begin
            bus.rx_ready = ($urandom_range(0, 1) != 0);
            for (int w = 0; w < NUM_WORDS; w++) begin
                if ($urandom_range(0, 3) != 0)
                    load_word(AW'(w), DATA_W'($urandom_range(0, 255)));
            end
            pulse_start();
            wait_done(600, 1);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
